// File: rtl/branch_unit_pipelined_pkg.sv
// Shared types for the branch/jump execution unit.
package branch_unit_pipelined_pkg;

  typedef enum logic [3:0] {
    JAL  = 4'd0,
    JALR = 4'd1,
    BEQ  = 4'd2,
    BNE  = 4'd3,
    BLT  = 4'd4,
    BGE  = 4'd5,
    BLTU = 4'd6,
    BGEU = 4'd7
  } instr_name_e;

endpackage

// File: rtl/branch_unit_pipelined.sv
// Branch/jump execution unit: resolve at issue, one stage register, then an
// in-order result FIFO toward the CDB with backpressure and flush.
module branch_unit_pipelined
  import branch_unit_pipelined_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 6,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  instr_name_e          i_instr_name,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [XLEN-1:0]      i_data_1,
  input  logic [XLEN-1:0]      i_data_2,
  input  logic [XLEN-1:0]      i_address,
  input  logic [XLEN-1:0]      i_immediate,
  input  logic                 i_pred_taken,
  input  logic [XLEN-1:0]      i_pred_target,
  output logic                 o_valid,
  input  logic                 i_result_ready,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [XLEN-1:0]      o_store_result,
  output logic [XLEN-1:0]      o_jump_result,
  output logic                 o_taken,
  output logic                 o_mispredict,
  output logic                 o_misaligned,
  output logic                 o_illegal
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]      store;
    logic [XLEN-1:0]      jump;
    logic                 taken;
    logic                 mispredict;
    logic                 misaligned;
    logic                 illegal;
  } result_t;

  result_t           res_c;
  result_t           head_c;
  result_t           stage_q;
  result_t           mem_q [DEPTH];
  logic              stage_valid_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;

  logic [XLEN-1:0]   link_c;
  logic [XLEN-1:0]   pc_imm_c;
  logic [XLEN-1:0]   reg_imm_c;
  logic [XLEN-1:0]   pred_next_c;
  logic              is_branch_c;
  logic              cond_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  logic [OCC_W-1:0]  occ_c;

  // Resolve target, direction, link value and prediction check for the issuing op
  always_comb begin
    link_c      = i_address + XLEN'(4);
    pc_imm_c    = i_address + i_immediate;
    reg_imm_c   = (i_data_1 + i_immediate) & ~XLEN'(1);
    pred_next_c = i_pred_taken ? i_pred_target : link_c;
    is_branch_c = 1'b0;
    cond_c      = 1'b0;
    res_c       = '0;
    res_c.tag   = i_tag;
    res_c.jump  = link_c;
    case (i_instr_name)
      JAL: begin
        res_c.taken = 1'b1;
        res_c.jump  = pc_imm_c;
        res_c.store = link_c;
      end
      JALR: begin
        res_c.taken = 1'b1;
        res_c.jump  = reg_imm_c;
        res_c.store = link_c;
      end
      BEQ: begin
        is_branch_c = 1'b1;
        cond_c      = (i_data_1 == i_data_2);
      end
      BNE: begin
        is_branch_c = 1'b1;
        cond_c      = (i_data_1 != i_data_2);
      end
      BLT: begin
        is_branch_c = 1'b1;
        cond_c      = ($signed(i_data_1) < $signed(i_data_2));
      end
      BGE: begin
        is_branch_c = 1'b1;
        cond_c      = ($signed(i_data_1) >= $signed(i_data_2));
      end
      BLTU: begin
        is_branch_c = 1'b1;
        cond_c      = (i_data_1 < i_data_2);
      end
      BGEU: begin
        is_branch_c = 1'b1;
        cond_c      = (i_data_1 >= i_data_2);
      end
      default: res_c.illegal = 1'b1;
    endcase
    if (is_branch_c && cond_c) begin
      res_c.taken = 1'b1;
      res_c.jump  = pc_imm_c;
    end
    res_c.misaligned = res_c.taken & res_c.jump[1];
    res_c.mispredict = (res_c.jump != pred_next_c) | res_c.misaligned;
  end

  // Occupancy counts the stage register too, so the stage can always drain into the FIFO
  assign o_valid  = (count_q != '0);
  assign pop_c    = o_valid & i_result_ready;
  assign occ_c    = OCC_W'(count_q) + OCC_W'(stage_valid_q) - OCC_W'(pop_c);
  assign o_ready  = ~i_reset & (occ_c < OCC_W'(DEPTH));
  assign accept_c = i_valid & o_ready & ~i_flush;
  assign push_c   = stage_valid_q & ((count_q < CNT_W'(DEPTH)) | pop_c);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stage_valid_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else if (i_flush) begin
      stage_valid_q <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= wr_ptr_q;
    end else begin
      if (accept_c)    stage_valid_q <= 1'b1;
      else if (push_c) stage_valid_q <= 1'b0;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed through the valid count
  always_ff @(posedge i_clock) begin
    if (accept_c) stage_q <= res_c;
    if (push_c)   mem_q[wr_ptr_q] <= stage_q;
  end

  assign head_c         = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_tag          = head_c.tag;
  assign o_store_result = head_c.store;
  assign o_jump_result  = head_c.jump;
  assign o_taken        = head_c.taken;
  assign o_mispredict   = head_c.mispredict;
  assign o_misaligned   = head_c.misaligned;
  assign o_illegal      = head_c.illegal;

endmodule
